// File: rtl/cpu.sv
// VeriRISC 8-bit accumulator CPU: PC, IR, ALU, phase sequencer and 32x8 unified memory.
// Latency: one instruction per 8 clocks (fetch=0) or 7 clocks (fetch=1); HLT freezes the core.
// Backpressure: none; the core free-runs from reset release until HLT, and only rst_ restarts it.

package typedefs;
    typedef enum logic [2:0] {
        HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
        XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } phase_t;
endpackage

// Unified 32x8 instruction/data memory.
// Latency: combinational read, write lands on the rising edge.
// Backpressure: none; contents are not cleared by reset.
module cpu_mem (
    input  logic       clk,
    input  logic       wr,
    input  logic [4:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    logic [7:0] memory [0:31];

    assign data_out = memory[addr];

    // Store the accumulator when the controller strobes wr
    always_ff @(posedge clk) begin
        if (wr) begin
            memory[addr] <= data_in;
        end
    end
endmodule

// Top level: sequencer, datapath registers and the memory instance.
// Latency: 8 or 7 clocks per instruction depending on fetch.
// Backpressure: none; halt is sticky until rst_.
module cpu
    import typedefs::*;
(
    input  logic clk,
    input  logic rst_,
    input  logic alu_clk,
    input  logic fetch,
    output logic halt,
    output logic load_ir
);
    phase_t     phase_q, phase_d;
    logic [4:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] accum_q, accum_d;
    logic       halt_q, halt_d;

    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr;
    logic       zero, aluop;
    logic [4:0] addr;

    opcode_t    opcode;
    logic [4:0] pc_addr;
    logic [7:0] accum;
    logic [7:0] alu_out;
    logic [7:0] data_out;

    // The ALU strobe is kept on the port for compatibility but has no effect.
    logic       alu_clk_unused;
    assign alu_clk_unused = alu_clk;

    assign opcode  = opcode_t'(ir_q[7:5]);
    assign pc_addr = pc_q;
    assign accum   = accum_q;
    assign zero    = (accum_q == 8'h00);
    assign aluop   = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
    assign addr    = sel ? pc_q : ir_q[4:0];
    assign halt    = halt_q;
    assign load_ir = ld_ir;

    cpu_mem memory1 (
        .clk      (clk),
        .wr       (wr),
        .addr     (addr),
        .data_in  (accum_q),
        .data_out (data_out)
    );

    // ALU: 8-bit, carry out of ADD is dropped
    always_comb begin
        alu_out = accum_q;
        case (opcode)
            ADD:     alu_out = accum_q + data_out;
            AND:     alu_out = accum_q & data_out;
            XOR:     alu_out = accum_q ^ data_out;
            LDA:     alu_out = data_out;
            default: alu_out = accum_q;
        endcase
    end

    // Phase decode and next phase; a set halt blocks every strobe so the core freezes
    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        halt_d  = halt_q;
        phase_d = phase_q;
        if (!halt_q) begin
            case (phase_q)
                INST_ADDR: begin
                    sel     = 1'b1;
                    phase_d = INST_FETCH;
                end
                INST_FETCH: begin
                    sel     = 1'b1;
                    rd      = 1'b1;
                    phase_d = INST_LOAD;
                end
                INST_LOAD: begin
                    sel     = 1'b1;
                    rd      = 1'b1;
                    ld_ir   = 1'b1;
                    phase_d = fetch ? OP_ADDR : IDLE;
                end
                IDLE: begin
                    sel     = 1'b1;
                    rd      = 1'b1;
                    ld_ir   = 1'b1;
                    phase_d = OP_ADDR;
                end
                OP_ADDR: begin
                    inc_pc  = 1'b1;
                    halt_d  = (opcode == HLT);
                    phase_d = OP_FETCH;
                end
                OP_FETCH: begin
                    rd      = aluop;
                    phase_d = ALU_OP;
                end
                ALU_OP: begin
                    rd      = aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    ld_pc   = (opcode == JMP);
                    phase_d = STORE;
                end
                STORE: begin
                    rd      = aluop;
                    ld_ac   = aluop;
                    ld_pc   = (opcode == JMP);
                    wr      = (opcode == STO);
                    phase_d = INST_ADDR;
                end
                default: phase_d = INST_ADDR;
            endcase
        end
    end

    // Datapath register next values; a jump outranks the PC increment
    always_comb begin
        ir_d    = (ld_ir && rd) ? data_out : ir_q;
        accum_d = (ld_ac && rd) ? alu_out : accum_q;
        if (ld_pc) begin
            pc_d = ir_q[4:0];
        end else if (inc_pc) begin
            pc_d = pc_q + 5'd1;
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers; reset aborts any instruction and restarts at address 0
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q <= INST_ADDR;
            pc_q    <= 5'd0;
            ir_q    <= 8'h00;
            accum_q <= 8'h00;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            accum_q <= accum_d;
            halt_q  <= halt_d;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the VeriRISC core: ALU vectors in both fetch modes,
// SKZ/JMP/PC-wrap programs, a Fibonacci loop, reset abort and load_ir timing.
// Programs are preloaded into the memory array hierarchically while rst_ is low.
module tb_cpu;
    import typedefs::*;

    logic clk;
    logic rst_;
    logic alu_clk;
    logic fetch;
    logic halt;
    logic load_ir;

    int total;
    int passed;
    int cyc;

    cpu dut (
        .clk     (clk),
        .rst_    (rst_),
        .alu_clk (alu_clk),
        .fetch   (fetch),
        .halt    (halt),
        .load_ir (load_ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial alu_clk = 1'b0;
    always #7 alu_clk = ~alu_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        opcode_t    op1;
        logic [7:0] b;
        opcode_t    op2;
        logic [7:0] c;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [7:0] ins(input opcode_t op, input logic [4:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        dut.memory1.memory[a] <= d;
    endtask

    // Hold the core in reset and clear memory (all zero words decode as HLT)
    task automatic begin_load();
        @(negedge clk);
        rst_ = 1'b0;
        for (int i = 0; i < 32; i++) begin
            dut.memory1.memory[i] <= 8'h00;
        end
    endtask

    task automatic go(input logic f);
        fetch = f;
        @(negedge clk);
        rst_ = 1'b1;
        cyc  = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_halt(input string name, input int limit);
        while (halt !== 1'b1 && cyc < limit) begin
            step(1);
        end
        chk({name, "_halt"}, halt, 1);
    endtask

    initial begin
        logic [7:0] fib_exp [7];
        int nld;

        total   = 0;
        passed  = 0;
        cyc     = 0;
        rst_    = 1'b1;
        fetch   = 1'b0;

        vecs[0] = '{8'h05, ADD, 8'h03, ADD, 8'h00, 8'h08};
        vecs[1] = '{8'hF0, AND, 8'h0F, XOR, 8'hFF, 8'hFF};
        vecs[2] = '{8'hFF, ADD, 8'h02, ADD, 8'h00, 8'h01};
        vecs[3] = '{8'hF0, XOR, 8'hFF, AND, 8'h3C, 8'h0C};
        vecs[4] = '{8'h12, LDA, 8'h34, ADD, 8'h01, 8'h35};

        fib_exp = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};

        // Reset state
        #3 rst_ = 1'b0;
        #2;
        chk("rst_pc", dut.pc_addr, 0);
        chk("rst_accum", dut.accum, 0);
        chk("rst_halt", halt, 0);
        chk("rst_load_ir", load_ir, 0);

        // ALU vectors: LDA a; op1 b; op2 c; STO 1C; HLT -- in both fetch modes
        for (int v = 0; v < 5; v++) begin
            for (int f = 0; f < 2; f++) begin
                begin_load();
                poke(5'h00, ins(LDA, 5'h1A));
                poke(5'h01, ins(vecs[v].op1, 5'h1B));
                poke(5'h02, ins(vecs[v].op2, 5'h1D));
                poke(5'h03, ins(STO, 5'h1C));
                poke(5'h04, ins(HLT, 5'h00));
                poke(5'h1A, vecs[v].a);
                poke(5'h1B, vecs[v].b);
                poke(5'h1D, vecs[v].c);
                go(f[0]);
                wait_halt($sformatf("v%0d_f%0d", v, f), 200);
                chk($sformatf("v%0d_f%0d_cycles", v, f), cyc, (f == 0) ? 37 : 32);
                chk($sformatf("v%0d_f%0d_accum", v, f), dut.accum, vecs[v].exp);
                chk($sformatf("v%0d_f%0d_mem1c", v, f), dut.memory1.memory[5'h1C], vecs[v].exp);
                chk($sformatf("v%0d_f%0d_pc", v, f), dut.pc_addr, 5);
                step(16);
                chk($sformatf("v%0d_f%0d_frozen_pc", v, f), dut.pc_addr, 5);
                chk($sformatf("v%0d_f%0d_frozen_accum", v, f), dut.accum, vecs[v].exp);
            end
        end

        // load_ir width per instruction and opcode timing
        for (int f = 0; f < 2; f++) begin
            begin_load();
            poke(5'h00, ins(LDA, 5'h1A));
            poke(5'h01, ins(HLT, 5'h00));
            go(f[0]);
            nld = 0;
            for (int k = 1; k <= ((f == 0) ? 8 : 7); k++) begin
                step(1);
                if (load_ir === 1'b1) nld++;
                if (k == 2) chk($sformatf("f%0d_opcode_before_ld", f), dut.opcode, HLT);
                if (k == 3) chk($sformatf("f%0d_opcode_after_ld", f), dut.opcode, LDA);
            end
            chk($sformatf("f%0d_load_ir_cycles", f), nld, (f == 0) ? 2 : 1);
        end

        // SKZ taken (accum zero) and not taken
        for (int z = 0; z < 2; z++) begin
            begin_load();
            poke(5'h00, ins(LDA, 5'h1A));
            poke(5'h01, ins(SKZ, 5'h00));
            poke(5'h02, ins(ADD, 5'h1B));
            poke(5'h03, ins(ADD, 5'h1D));
            poke(5'h04, ins(STO, 5'h1C));
            poke(5'h05, ins(HLT, 5'h00));
            poke(5'h1A, (z == 0) ? 8'h00 : 8'h02);
            poke(5'h1B, 8'h07);
            poke(5'h1D, 8'h01);
            go(1'b0);
            step(16);
            chk($sformatf("skz%0d_pc_after_skz", z), dut.pc_addr, (z == 0) ? 3 : 2);
            wait_halt($sformatf("skz%0d", z), 200);
            chk($sformatf("skz%0d_cycles", z), cyc, (z == 0) ? 37 : 45);
            chk($sformatf("skz%0d_accum", z), dut.accum, (z == 0) ? 8'h01 : 8'h0A);
            chk($sformatf("skz%0d_pc", z), dut.pc_addr, 6);
        end

        // JMP 0x10 from address 4; the STO at 5 must never run
        begin_load();
        poke(5'h00, ins(LDA, 5'h1A));
        poke(5'h01, ins(ADD, 5'h1B));
        poke(5'h02, ins(SKZ, 5'h00));
        poke(5'h03, ins(XOR, 5'h1D));
        poke(5'h04, ins(JMP, 5'h10));
        poke(5'h05, ins(STO, 5'h1C));
        poke(5'h06, ins(HLT, 5'h00));
        poke(5'h10, ins(STO, 5'h1E));
        poke(5'h11, ins(HLT, 5'h00));
        poke(5'h1A, 8'h11);
        poke(5'h1B, 8'h01);
        go(1'b0);
        step(40);
        chk("jmp_pc_after_store", dut.pc_addr, 5'h10);
        wait_halt("jmp", 200);
        chk("jmp_cycles", cyc, 53);
        chk("jmp_mem1e", dut.memory1.memory[5'h1E], 8'h12);
        chk("jmp_mem1c_untouched", dut.memory1.memory[5'h1C], 8'h00);
        chk("jmp_pc", dut.pc_addr, 5'h12);

        // PC wrap 31 -> 0, fetch=1
        begin_load();
        poke(5'h00, ins(SKZ, 5'h00));
        poke(5'h01, ins(HLT, 5'h00));
        poke(5'h02, ins(JMP, 5'h1F));
        poke(5'h1F, ins(LDA, 5'h1E));
        poke(5'h1E, 8'h44);
        go(1'b1);
        wait_halt("wrap", 200);
        chk("wrap_cycles", cyc, 32);
        chk("wrap_accum", dut.accum, 8'h44);
        chk("wrap_pc", dut.pc_addr, 2);

        // Fibonacci loop: 7 passes, mem[1B] holds the newest term after each
        begin_load();
        poke(5'h00, ins(LDA, 5'h1A));
        poke(5'h01, ins(ADD, 5'h1B));
        poke(5'h02, ins(STO, 5'h1C));
        poke(5'h03, ins(LDA, 5'h1B));
        poke(5'h04, ins(STO, 5'h1A));
        poke(5'h05, ins(LDA, 5'h1C));
        poke(5'h06, ins(STO, 5'h1B));
        poke(5'h07, ins(LDA, 5'h1D));
        poke(5'h08, ins(ADD, 5'h1E));
        poke(5'h09, ins(STO, 5'h1D));
        poke(5'h0A, ins(SKZ, 5'h00));
        poke(5'h0B, ins(JMP, 5'h00));
        poke(5'h0C, ins(HLT, 5'h00));
        poke(5'h1A, 8'd1);
        poke(5'h1B, 8'd0);
        poke(5'h1D, 8'd7);
        poke(5'h1E, 8'hFF);
        go(1'b0);
        for (int k = 0; k < 6; k++) begin
            step(96);
            chk($sformatf("fib_pass%0d", k + 1), dut.memory1.memory[5'h1B], fib_exp[k]);
        end
        wait_halt("fib", 800);
        chk("fib_cycles", cyc, 669);
        chk("fib_final", dut.memory1.memory[5'h1B], fib_exp[6]);
        chk("fib_pc", dut.pc_addr, 13);

        // Reset mid-instruction, then a clean rerun of LDA/ADD/STO/HLT
        begin_load();
        poke(5'h00, ins(LDA, 5'h1A));
        poke(5'h01, ins(ADD, 5'h1B));
        poke(5'h02, ins(STO, 5'h1C));
        poke(5'h03, ins(HLT, 5'h00));
        poke(5'h1A, 8'h05);
        poke(5'h1B, 8'h03);
        go(1'b0);
        step(13);
        chk("mid_pc", dut.pc_addr, 2);
        chk("mid_accum", dut.accum, 8'h05);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("abort_pc", dut.pc_addr, 0);
        chk("abort_accum", dut.accum, 0);
        chk("abort_halt", halt, 0);
        chk("abort_mem00", dut.memory1.memory[5'h00], ins(LDA, 5'h1A));
        chk("abort_mem1a", dut.memory1.memory[5'h1A], 8'h05);
        go(1'b0);
        wait_halt("rerun", 200);
        chk("rerun_cycles", cyc, 29);
        chk("rerun_accum", dut.accum, 8'h08);
        chk("rerun_mem1c", dut.memory1.memory[5'h1C], 8'h08);
        chk("rerun_pc", dut.pc_addr, 4);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("halt_cleared_by_reset", halt, 0);
        chk("mem1c_kept_over_reset", dut.memory1.memory[5'h1C], 8'h08);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
